// File: rtl/coin_sequencer.sv
// coin_sequencer: synchronises/debounces coin sensors, queues coin codes, streams them to the vending FSM.
// Optional inactivity auto-flush enabled by defining COIN_TIMEOUT_EN.
module coin_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              coin5,
  input  logic                              coin10,
  input  logic                              vend_req,
  output logic [1:0]                        coin_out,
  output logic                              busy,
  output logic                              coin_reject,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   coin_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  if (DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("coin_sequencer: invalid parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_TERM} state_t;

  state_t          r_state, w_state_nx;
  logic            r_s5_meta, r_s5_sync, r_s10_meta, r_s10_sync;
  logic [DW-1:0]   r_cnt5, r_cnt10;
  logic            r_ev5, r_ev10;
  logic [1:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_count;
  logic [1:0]      r_coin_out;
  logic            r_busy, r_reject;

  logic            w_push, w_pop, w_reject_nx, w_busy_nx, w_timeout;
  logic            w_ev_any, w_both, w_full, w_accept;
  logic [1:0]      w_code, w_out_nx;

  // Two-flop synchronisers and saturating debounce counters; event pulses once per rising level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s5_meta  <= 1'b0;
      r_s5_sync  <= 1'b0;
      r_s10_meta <= 1'b0;
      r_s10_sync <= 1'b0;
      r_cnt5     <= '0;
      r_cnt10    <= '0;
      r_ev5      <= 1'b0;
      r_ev10     <= 1'b0;
    end else begin
      r_s5_meta  <= coin5;
      r_s5_sync  <= r_s5_meta;
      r_s10_meta <= coin10;
      r_s10_sync <= r_s10_meta;
      if (!r_s5_sync)                            r_cnt5 <= '0;
      else if (r_cnt5 != DW'(DEBOUNCE_CYCLES))   r_cnt5 <= r_cnt5 + DW'(1);
      if (!r_s10_sync)                           r_cnt10 <= '0;
      else if (r_cnt10 != DW'(DEBOUNCE_CYCLES))  r_cnt10 <= r_cnt10 + DW'(1);
      r_ev5  <= r_s5_sync  && (r_cnt5  == DW'(DEBOUNCE_CYCLES - 1));
      r_ev10 <= r_s10_sync && (r_cnt10 == DW'(DEBOUNCE_CYCLES - 1));
    end
  end

  assign w_ev_any = r_ev5 | r_ev10;
  assign w_both   = r_ev5 & r_ev10;
  assign w_code   = r_ev10 ? 2'b10 : 2'b01;
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_accept = w_ev_any && !w_both && !w_full;

`ifdef COIN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_timer;

  // Inactivity timer: runs only in COLLECT, restarts on every push.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_COLLECT || w_push) r_timer <= '0;
    else if (!w_timeout)                       r_timer <= r_timer + TW'(1);
  end

  assign w_timeout = (r_state == S_COLLECT) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_reject_nx = 1'b0;
    w_busy_nx   = 1'b0;
    w_out_nx    = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_push     = 1'b1;
          w_state_nx = S_COLLECT;
        end else if (w_ev_any) begin
          w_reject_nx = 1'b1;
        end
      end
      S_COLLECT: begin
        if (w_accept)      w_push      = 1'b1;
        else if (w_ev_any) w_reject_nx = 1'b1;
        // A coin arriving with vend_req is pushed this cycle and so joins the stream.
        if (vend_req || (w_timeout && !w_push)) w_state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        w_busy_nx   = 1'b1;
        w_reject_nx = w_ev_any;
        if (r_count != '0) begin
          w_pop    = 1'b1;
          w_out_nx = r_mem[r_rd];
        end
        if (r_count <= CW'(1)) w_state_nx = S_TERM;
      end
      S_TERM: begin
        w_busy_nx   = 1'b1;
        w_reject_nx = w_ev_any;
        w_state_nx  = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Coin FIFO; occupancy count tells full from empty since pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= 2'b00;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_code;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_coin_out <= 2'b00;
      r_busy     <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      r_coin_out <= w_out_nx;
      r_busy     <= w_busy_nx;
      r_reject   <= w_reject_nx;
    end
  end

  assign coin_out    = r_coin_out;
  assign busy        = r_busy;
  assign coin_reject = r_reject;
  assign coin_count  = r_count;

endmodule

// File: doc/coin_sequencer.md
# coin_sequencer

- Upstream stage of the vending-machine FSM: turns raw, asynchronous coin-sensor lines into the FSM's 2-bit coin code (01 = 5rs, 10 = 10rs, 00 = no coin / end of transaction).
- Synchronises and debounces each sensor, then queues accepted coins in a small FIFO.
- On a vend request, or after an inactivity timeout, streams the queued codes on consecutive cycles, followed by one 00 terminator cycle.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high cycles required to accept a coin (≥1).
- FIFO_DEPTH, 4: coin queue depth (power of two, ≥2).
- TIMEOUT_CYCLES, 1000: inactivity cycles in COLLECT before auto-flush (used only with COIN_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- coin5  in  1  raw 5rs sensor, asynchronous.
- coin10  in  1  raw 10rs sensor, asynchronous.
- vend_req  in  1  customer vend button, synchronous, level-sampled.
- coin_out  out  2  registered coin code to the vending FSM input.
- busy  out  1  high in FLUSH and TERM.
- coin_reject  out  1  one-cycle pulse when a detected coin is discarded.
- coin_count  out  clog2(FIFO_DEPTH+1)  coins currently queued.

## Operation
- Each raw line passes through a 2-flop synchroniser, then a per-line debounce counter.
- The counter increments while the synced level is 1 and clears to 0 when it is 0; it saturates at DEBOUNCE_CYCLES.
- A coin event fires once, on the cycle the counter reaches DEBOUNCE_CYCLES. The line must drop to 0 before that line can fire again.
- Both lines firing in the same cycle: both are discarded and coin_reject pulses.
- An event while the FIFO is full, or while in FLUSH/TERM: the coin is discarded and coin_reject pulses.
- FSM states:
  - IDLE: coin_out = 00. An accepted coin is pushed and the state moves to COLLECT. vend_req is ignored.
  - COLLECT: coin_out = 00. Each accepted coin is pushed and clears the timeout timer. vend_req = 1 moves to FLUSH; so does timer == TIMEOUT_CYCLES-1 (macro only).
  - FLUSH: each cycle coin_out = FIFO head code and the head is popped. When the last entry pops, move to TERM.
  - TERM: coin_out = 00 for exactly one cycle, then IDLE.
- A push and a vend_req in the same COLLECT cycle: the coin is pushed first, then FLUSH, and the coin is included in the stream.
- coin_count counts pushes minus pops; it never exceeds FIFO_DEPTH.

## Timing
- Reset values:
  - coin_out = 00, busy = 0, coin_reject = 0, coin_count = 0.
  - FIFO pointers and contents cleared, synchronisers and debounce counters 0, state IDLE.
- Coin acceptance latency: raw line high at edge N gives the event at edge N+1+DEBOUNCE_CYCLES, provided the line stays high. coin_count updates at the following edge.
- vend_req sampled high at edge N in COLLECT:
  - coin_out carries the first code from edge N+1 through N+2.
  - K queued coins occupy K consecutive cycles, then one 00 cycle.
  - busy is high for K+1 cycles.
- The stream has no gaps. The downstream FSM needs back-to-back codes, and a 00 ends its transaction.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by coin_count.
- rst asserted in any state: all state returns to reset values at that edge. Queued coins are lost, and coin_out is 00 from the next cycle.
- coin_reject is registered and high for exactly one cycle per discarded coin.

## Configuration
- COIN_TIMEOUT_EN defined:
  - An inactivity timer in COLLECT forces FLUSH after TIMEOUT_CYCLES cycles with no accepted coin.
  - The timer clears on every push and on entry to COLLECT.
- COIN_TIMEOUT_EN not defined:
  - No timer logic is present; only vend_req leaves COLLECT.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Single 5rs: coin5 high 8 cycles, then vend_req pulse → coin_out 01 for 1 cycle, then 00 for 1 cycle; busy high 2 cycles; coin_count 1→0.
- Ordering: 10rs then 5rs, then vend_req → coin_out sequence 10, 01, 00 on consecutive cycles; downstream FSM sees exactly that order.
- Glitch rejection (DEBOUNCE_CYCLES=4): coin10 high 3 cycles, then low → no event, coin_count 0, no coin_reject.
- Overflow (FIFO_DEPTH=4): five 5rs coins → coin_reject one pulse on the 5th; vend gives four 01 cycles then 00.
- Timeout (TIMEOUT_CYCLES=16, macro defined): one 10rs coin, no vend_req → FLUSH 16 cycles after acceptance, coin_out 10 then 00. Without the macro, coin_out stays 00 indefinitely.
- Reset mid-FLUSH: 3 coins queued, rst on the 2nd flush cycle → coin_out 00 next cycle, busy 0, coin_count 0, state IDLE.
